// File: rtl/cas_rec_pkg.sv
// Shared types and constants for the cassette record path.
// Covers the recorder state encoding, the leader sync byte and the period counter width.
package cas_rec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HUNT   = 2'd1,
      SYNCED = 2'd2
   } rec_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'h55;

   localparam int PERIOD_W = 12;
   localparam logic [PERIOD_W-1:0] PERIOD_MAX = {PERIOD_W{1'b1}};

endpackage

// File: rtl/cas_period_meter.sv
// Turns the CoCo DAC waveform into FSK bits by timing rising zero crossings.
// Also flags carrier loss when no crossing arrives for a long time.
module cas_period_meter
   import cas_rec_pkg::*;
#(
   parameter int TICKS_PER_US  = 57,
   parameter int MID_LEVEL     = 32,
   parameter int HYST          = 4,
   parameter int MIN_PERIOD_US = 200,
   parameter int BIT_THRESH_US = 625,
   parameter int GAP_US        = 2000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic [5:0] dac_in,
   output logic       bit_valid,
   output logic       rx_bit,
   output logic       gap
);

   localparam logic [15:0]         PRESC_LAST = 16'(TICKS_PER_US - 1);
   localparam logic [5:0]          LEVEL_HI   = 6'(MID_LEVEL + HYST);
   localparam logic [5:0]          LEVEL_LO   = 6'(MID_LEVEL - HYST);
   localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD_US);
   localparam logic [PERIOD_W-1:0] THRESH_P   = PERIOD_W'(BIT_THRESH_US);
   localparam logic [PERIOD_W-1:0] GAP_P      = PERIOD_W'(GAP_US);

   logic [15:0]         presc_q, presc_d;
   logic                comp_q, comp_d;
   logic                comp_prev_q, comp_prev_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                started_q, started_d;
   logic                bit_valid_q, bit_valid_d;
   logic                rx_bit_q, rx_bit_d;

   logic us_tick;
   logic rise;
   logic gap_hit;
   logic rise_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q     <= '0;
         comp_q      <= 1'b0;
         comp_prev_q <= 1'b0;
         cnt_q       <= '0;
         started_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         rx_bit_q    <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         comp_q      <= comp_d;
         comp_prev_q <= comp_prev_d;
         cnt_q       <= cnt_d;
         started_q   <= started_d;
         bit_valid_q <= bit_valid_d;
         rx_bit_q    <= rx_bit_d;
      end
   end

   // A crossing that arrives before the counter has been started, or after carrier loss,
   // only restarts timing; a too-short one is treated as a glitch and leaves the counter running.
   always_comb begin
      us_tick = (presc_q == PRESC_LAST);
      presc_d = us_tick ? 16'd0 : presc_q + 16'd1;

      if (dac_in >= LEVEL_HI) begin
         comp_d = 1'b1;
      end else if (dac_in <= LEVEL_LO) begin
         comp_d = 1'b0;
      end else begin
         comp_d = comp_q;
      end
      comp_prev_d = comp_q;

      rise    = comp_q & ~comp_prev_q;
      gap_hit = started_q && (cnt_q >= GAP_P);
      rise_ok = rise && (!started_q || gap_hit || (cnt_q >= MIN_P));

      cnt_d = cnt_q;
      if (clear || rise_ok) begin
         cnt_d = '0;
      end else if (us_tick && (cnt_q != PERIOD_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end

      started_d = started_q;
      if (clear) begin
         started_d = 1'b0;
      end else if (rise_ok) begin
         started_d = 1'b1;
      end else if (gap_hit) begin
         started_d = 1'b0;
      end

      bit_valid_d = !clear && rise_ok && started_q && !gap_hit;
      rx_bit_d    = (cnt_q < THRESH_P);
   end

   assign bit_valid = bit_valid_q;
   assign rx_bit    = rx_bit_q;
   assign gap       = gap_hit;

endmodule

// File: rtl/cas_recorder.sv
// Cassette record path: aligns decoded FSK bits on the 0x55 leader and
// writes byte-aligned data into the tape buffer RAM.
module cas_recorder
   import cas_rec_pkg::*;
#(
   parameter int TICKS_PER_US  = 57,
   parameter int MID_LEVEL     = 32,
   parameter int HYST          = 4,
   parameter int MIN_PERIOD_US = 200,
   parameter int BIT_THRESH_US = 625,
   parameter int GAP_US        = 2000,
   parameter int ADDR_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        dac_in,
   input  logic              motor,
   input  logic              rec_arm,
   input  logic              rec_clear,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [ADDR_W-1:0] rec_len,
   output logic              rec_active,
   output logic              overflow
);

   localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

   rec_state_t state_q, state_d;

   logic [7:0]        shift_q, shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              full_q, full_d;
   logic              overflow_q, overflow_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;

   logic       bit_valid;
   logic       rx_bit;
   logic       gap;
   logic       run;
   logic [7:0] shift_next;
   logic       byte_done;
   logic       meter_clear;
   logic       rec_active_o;

   cas_period_meter #(
      .TICKS_PER_US (TICKS_PER_US),
      .MID_LEVEL    (MID_LEVEL),
      .HYST         (HYST),
      .MIN_PERIOD_US(MIN_PERIOD_US),
      .BIT_THRESH_US(BIT_THRESH_US),
      .GAP_US       (GAP_US)
   ) u_meter (
      .clk      (clk),
      .reset    (reset),
      .clear    (meter_clear),
      .dac_in   (dac_in),
      .bit_valid(bit_valid),
      .rx_bit   (rx_bit),
      .gap      (gap)
   );

   assign run        = motor & rec_arm;
   assign shift_next = {rx_bit, shift_q[7:1]};
   assign byte_done  = run && !gap && bit_valid &&
                       (((state_q == HUNT) && (shift_next == SYNC_BYTE)) ||
                        ((state_q == SYNCED) && (bit_cnt_q == 3'd7)));

   always_ff @(posedge clk) begin
      if (reset || rec_clear) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!run) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = HUNT;
            HUNT:    if (byte_done) state_d = SYNCED;
            SYNCED:  if (gap) state_d = HUNT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      rec_active_o = (state_q == SYNCED);
      meter_clear  = (state_q == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset || rec_clear) begin
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         ptr_q      <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         ptr_q      <= ptr_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Partial bytes are thrown away on motor/arm drop and on carrier loss; once the
   // last address has been written the pointer parks there and further bytes only flag overflow.
   always_comb begin
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      ptr_d      = ptr_q;
      full_d     = full_q;
      overflow_d = overflow_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      if (!run || (state_q == IDLE) || gap) begin
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (bit_valid) begin
         shift_d   = shift_next;
         bit_cnt_d = (state_q == SYNCED) ? bit_cnt_q + 3'd1 : 3'd0;
         if (byte_done) begin
            if (full_q) begin
               overflow_d = 1'b1;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q;
               wr_data_d = shift_next;
               if (ptr_q == PTR_LAST) begin
                  full_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign rec_len    = ptr_q;
   assign rec_active = rec_active_o;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_cas_recorder.sv
// Directed bench for cas_recorder with time constants scaled down so that
// whole tape bytes fit in a short run; a 4-bit buffer exercises the full/overflow path.
module tb_cas_recorder;
   import cas_rec_pkg::*;

   localparam int TICKS     = 2;
   localparam int MIN_US    = 20;
   localparam int THRESH_US = 60;
   localparam int GAP_TB_US = 200;
   localparam int AW        = 4;
   localparam int ONE_HALF  = 16;
   localparam int ZERO_HALF = 40;
   localparam logic [5:0] DAC_HI = 6'd50;
   localparam logic [5:0] DAC_LO = 6'd16;

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    dac_in;
   logic          motor;
   logic          rec_arm;
   logic          rec_clear;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [AW-1:0] rec_len;
   logic          rec_active;
   logic          overflow;

   int total = 0;
   int bad = 0;
   int double_wr = 0;
   logic wr_en_prev = 1'b0;
   logic [AW-1:0] q_addr[$];
   logic [7:0]    q_data[$];

   always #5 clk = ~clk;

   cas_recorder #(
      .TICKS_PER_US (TICKS),
      .MID_LEVEL    (32),
      .HYST         (4),
      .MIN_PERIOD_US(MIN_US),
      .BIT_THRESH_US(THRESH_US),
      .GAP_US       (GAP_TB_US),
      .ADDR_W       (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .dac_in    (dac_in),
      .motor     (motor),
      .rec_arm   (rec_arm),
      .rec_clear (rec_clear),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rec_len   (rec_len),
      .rec_active(rec_active),
      .overflow  (overflow)
   );

   // Log every buffer write and catch strobes that last longer than one clock.
   always @(negedge clk) begin
      if (wr_en) begin
         q_addr.push_back(wr_addr);
         q_data.push_back(wr_data);
         if (wr_en_prev) double_wr <= double_wr + 1;
      end
      wr_en_prev <= wr_en;
   end

   initial begin
      repeat (100000) @(posedge clk);
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic checkWrite(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] got_a;
      logic [31:0] got_d;
      got_a = (idx < q_addr.size()) ? 32'(q_addr[idx]) : 32'hFFFF_FFFF;
      got_d = (idx < q_data.size()) ? 32'(q_data[idx]) : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s_addr%0d", tag, idx), got_a, a);
      checkOutput($sformatf("%s_data%0d", tag, idx), got_d, d);
   endtask

   task automatic clearLog();
      q_addr.delete();
      q_data.delete();
   endtask

   task automatic waitUs(input int us);
      repeat (us * TICKS) @(negedge clk);
   endtask

   // One FSK cycle: high half then low half; an optional short dip early in the
   // high half produces a glitch crossing that must be rejected.
   task automatic sendBit(input logic b, input logic dip);
      int half;
      half = b ? ONE_HALF : ZERO_HALF;
      dac_in = DAC_HI;
      if (dip) begin
         waitUs(5);
         dac_in = DAC_LO;
         waitUs(5);
         dac_in = DAC_HI;
         waitUs(half - 10);
      end else begin
         waitUs(half);
      end
      dac_in = DAC_LO;
      waitUs(half);
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int glitch_bit);
      for (int i = 0; i < 8; i++) sendBit(b[i], i == glitch_bit);
   endtask

   // A final rising edge closes the last cycle, then silence longer than the gap.
   task automatic endBurst();
      dac_in = DAC_HI;
      waitUs(10);
      dac_in = DAC_LO;
      waitUs(GAP_TB_US + 100);
   endtask

   task automatic pulseClear();
      rec_clear = 1'b1;
      @(negedge clk);
      rec_clear = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      dac_in = DAC_LO;
      motor = 1'b0;
      rec_arm = 1'b0;
      rec_clear = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
      checkOutput("rst_rec_len", 32'(rec_len), 32'd0);
      checkOutput("rst_rec_active", 32'(rec_active), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] noise inside hysteresis");
      motor = 1'b1;
      rec_arm = 1'b1;
      waitUs(10);
      for (int i = 0; i < 40; i++) begin
         dac_in = 6'd32;
         waitUs(10);
         dac_in = 6'd34;
         waitUs(10);
      end
      dac_in = DAC_LO;
      waitUs(10);
      checkOutput("noise_writes", 32'(q_addr.size()), 32'd0);
      checkOutput("noise_state", 32'(dut.state_q), 32'(HUNT));
      checkOutput("noise_rec_len", 32'(rec_len), 32'd0);

      $display("[TB] clean leader and three bytes");
      for (int i = 0; i < 10; i++) sendBit(1'b0, 1'b0);
      applyStimulus(8'h55, -1);
      applyStimulus(8'h55, -1);
      checkOutput("main_active", 32'(rec_active), 32'd1);
      checkOutput("main_early_writes", 32'(q_addr.size()), 32'd1);
      applyStimulus(8'h3C, -1);
      endBurst();
      checkOutput("main_writes", 32'(q_addr.size()), 32'd3);
      checkWrite("main", 0, 32'h0, 32'h55);
      checkWrite("main", 1, 32'h1, 32'h55);
      checkWrite("main", 2, 32'h2, 32'h3C);
      checkOutput("main_rec_len", 32'(rec_len), 32'd3);
      checkOutput("main_after_gap_active", 32'(rec_active), 32'd0);
      checkOutput("main_overflow", 32'(overflow), 32'd0);

      $display("[TB] clear then glitched stream");
      clearLog();
      pulseClear();
      checkOutput("clr_rec_len", 32'(rec_len), 32'd0);
      checkOutput("clr_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("clr_wr_data", 32'(wr_data), 32'd0);
      checkOutput("clr_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 10; i++) sendBit(1'b0, i == 4);
      applyStimulus(8'h55, 1);
      applyStimulus(8'h55, -1);
      applyStimulus(8'h3C, 2);
      endBurst();
      checkOutput("glitch_writes", 32'(q_addr.size()), 32'd3);
      checkWrite("glitch", 0, 32'h0, 32'h55);
      checkWrite("glitch", 1, 32'h1, 32'h55);
      checkWrite("glitch", 2, 32'h2, 32'h3C);

      $display("[TB] carrier gap mid-byte");
      clearLog();
      applyStimulus(8'h55, -1);
      for (int i = 0; i < 4; i++) sendBit(1'b0, 1'b0);
      endBurst();
      checkOutput("gap_partial_writes", 32'(q_addr.size()), 32'd1);
      checkOutput("gap_state", 32'(dut.state_q), 32'(HUNT));
      applyStimulus(8'h55, -1);
      applyStimulus(8'hAA, -1);
      endBurst();
      checkOutput("gap_writes", 32'(q_addr.size()), 32'd3);
      checkWrite("gap", 0, 32'h3, 32'h55);
      checkWrite("gap", 1, 32'h4, 32'h55);
      checkWrite("gap", 2, 32'h5, 32'hAA);
      checkOutput("gap_rec_len", 32'(rec_len), 32'd6);

      $display("[TB] motor drop mid-byte");
      clearLog();
      applyStimulus(8'h55, -1);
      for (int i = 0; i < 5; i++) sendBit(1'b1, 1'b0);
      dac_in = DAC_HI;
      waitUs(10);
      dac_in = DAC_LO;
      waitUs(20);
      checkOutput("motor_active_before", 32'(rec_active), 32'd1);
      motor = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("motor_state", 32'(dut.state_q), 32'(IDLE));
      checkOutput("motor_active_after", 32'(rec_active), 32'd0);
      checkOutput("motor_writes", 32'(q_addr.size()), 32'd1);
      checkWrite("motor", 0, 32'h6, 32'h55);
      checkOutput("motor_rec_len", 32'(rec_len), 32'd7);

      $display("[TB] buffer full and overflow");
      clearLog();
      pulseClear();
      motor = 1'b1;
      waitUs(10);
      applyStimulus(8'h55, -1);
      for (int i = 1; i <= 17; i++) applyStimulus(8'(8'hE0 + i), -1);
      endBurst();
      checkOutput("full_writes", 32'(q_addr.size()), 32'd16);
      checkWrite("full", 0, 32'h0, 32'h55);
      for (int i = 1; i < 16; i++) checkWrite("full", i, 32'(i), 32'(8'hE0 + i));
      checkOutput("full_rec_len", 32'(rec_len), 32'd15);
      checkOutput("full_overflow", 32'(overflow), 32'd1);
      pulseClear();
      checkOutput("full_clr_rec_len", 32'(rec_len), 32'd0);
      checkOutput("full_clr_overflow", 32'(overflow), 32'd0);
      checkOutput("wr_en_width", 32'(double_wr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
